// File: rtl/pipe_exec_controller.sv
// Execution sequencer for the 5-stage pipeline: run / single-step / pause, halt on MEM/WB marker.
// Optional run watchdog is compiled in with `define PIPE_WATCHDOG_EN.
module pipe_exec_controller #(
  parameter int NB_CNT     = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              stop_i,
  input  logic              clear_i,
  input  logic              halt_wb_i,
  output logic              enable_pipe_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [1:0]        state_o,
  output logic [NB_CNT-1:0] cycle_count_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              enabled;

  // A non-positive limit would make the watchdog meaningless.
  if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
  end

  assign enabled = (state_q == RUN) || (state_q == STEP);

`ifdef PIPE_WATCHDOG_EN
  logic timeout_q, timeout_d;
  logic wdog_hit;

  assign wdog_hit  = (cnt_q == NB_CNT'(WDOG_LIMIT - 1));
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PIPE_WATCHDOG_EN
    timeout_d = timeout_q;
`endif
    // Every enabled edge counts, including the one that leaves for HALTED.
    if (enabled && (cnt_q != {NB_CNT{1'b1}})) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (run_i)        state_d = RUN;
        else if (step_i)  state_d = STEP;
        else if (clear_i) cnt_d   = '0;
      end
      RUN: begin
        if (halt_wb_i) state_d = HALTED;
`ifdef PIPE_WATCHDOG_EN
        else if (wdog_hit) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end
`endif
        else if (stop_i) state_d = IDLE;
      end
      STEP: begin
        state_d = halt_wb_i ? HALTED : IDLE;
      end
      HALTED: begin
        if (clear_i) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef PIPE_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef PIPE_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PIPE_WATCHDOG_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // Decoded straight from the state register so reset drops the enable asynchronously.
  assign enable_pipe_o = enabled;
  assign busy_o        = enabled;
  assign halted_o      = (state_q == HALTED);
  assign state_o       = state_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_pipe_exec_controller.sv
// Directed bench for pipe_exec_controller: vector table plus multi-cycle corner sequences.
// Built with a 4-bit counter and WDOG_LIMIT=8; watchdog expectations follow PIPE_WATCHDOG_EN.
module tb_pipe_exec_controller;

  localparam int NB_CNT = 4;
  localparam int WDOG   = 8;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              run_i = 1'b0, step_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, halt_wb_i = 1'b0;
  logic              enable_pipe_o, busy_o, halted_o, timeout_o;
  logic [1:0]        state_o;
  logic [NB_CNT-1:0] cycle_count_o;

  int tests  = 0;
  int failed = 0;

  pipe_exec_controller #(.NB_CNT(NB_CNT), .WDOG_LIMIT(WDOG)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .run_i        (run_i),
    .step_i       (step_i),
    .stop_i       (stop_i),
    .clear_i      (clear_i),
    .halt_wb_i    (halt_wb_i),
    .enable_pipe_o(enable_pipe_o),
    .busy_o       (busy_o),
    .halted_o     (halted_o),
    .state_o      (state_o),
    .cycle_count_o(cycle_count_o),
    .timeout_o    (timeout_o)
  );

  // ---------------- clock ----------------
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       run, step, stop, clr, halt;
    logic       en;
    logic [1:0] st;
    logic [3:0] cnt;
  } vec_t;

  vec_t vq[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic set_in(input logic r, s, p, c, h);
    run_i = r; step_i = s; stop_i = p; clear_i = c; halt_wb_i = h;
  endtask

  task automatic add(input logic r, s, p, c, h, input logic e, input logic [1:0] st,
                     input logic [3:0] cnt);
    vec_t v;
    v.run = r; v.step = s; v.stop = p; v.clr = c; v.halt = h;
    v.en = e; v.st = st; v.cnt = cnt;
    vq.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic [1:0] st,
                           input logic [3:0] cnt, input logic to);
    check({tag, "_en"},      32'(enable_pipe_o), 32'(en));
    check({tag, "_busy"},    32'(busy_o),        32'(en));
    check({tag, "_halted"},  32'(halted_o),      32'(st == 2'b11));
    check({tag, "_state"},   32'(state_o),       32'(st));
    check({tag, "_cnt"},     32'(cycle_count_o), 32'(cnt));
    check({tag, "_timeout"}, 32'(timeout_o),     32'(to));
  endtask

  initial begin
    logic [5:0] pattern;
    logic       wd;
`ifdef PIPE_WATCHDOG_EN
    wd = 1'b1;
`else
    wd = 1'b0;
`endif

    //        run step stop clr halt   en  st     cnt
    // run for six enabled cycles, halt on the sixth
    add(0,0,0,0,0, 0,2'b00,4'd0);
    add(1,0,0,0,0, 1,2'b01,4'd0);
    for (int i = 1; i <= 5; i++) add(0,0,0,0,0, 1,2'b01,4'(i));
    add(0,0,0,0,1, 0,2'b11,4'd6);
    // HALTED ignores run/step/stop/halt; clear returns to IDLE
    add(1,0,0,0,0, 0,2'b11,4'd6);
    add(0,1,0,0,0, 0,2'b11,4'd6);
    add(0,0,1,0,1, 0,2'b11,4'd6);
    add(0,0,0,1,0, 0,2'b00,4'd0);
    add(1,0,0,0,0, 1,2'b01,4'd0);
    add(0,0,0,0,0, 1,2'b01,4'd1);
    add(0,0,1,0,0, 0,2'b00,4'd2);
    add(1,0,1,0,0, 1,2'b01,4'd2);
    add(1,1,0,0,0, 1,2'b01,4'd3);
    add(0,0,1,0,0, 0,2'b00,4'd4);
    add(0,0,0,0,1, 0,2'b00,4'd4);
    add(0,0,0,1,0, 0,2'b00,4'd0);
    // stop and halt on the same edge: halt wins
    add(1,0,0,0,0, 1,2'b01,4'd0);
    for (int i = 1; i <= 4; i++) add(0,0,0,0,0, 1,2'b01,4'(i));
    add(0,0,1,0,1, 0,2'b11,4'd5);
    add(0,0,0,1,0, 0,2'b00,4'd0);
    // step that meets the halt marker
    add(0,1,0,0,0, 1,2'b10,4'd0);
    add(0,0,0,0,1, 0,2'b11,4'd1);
    add(0,0,0,1,0, 0,2'b00,4'd0);
    // run beats step; clear not honoured when leaving IDLE or while in RUN
    add(1,1,0,0,0, 1,2'b01,4'd0);
    add(0,0,1,0,0, 0,2'b00,4'd1);
    add(1,0,0,1,0, 1,2'b01,4'd1);
    add(0,0,1,1,0, 0,2'b00,4'd2);
    add(0,0,0,1,0, 0,2'b00,4'd0);

    // ---------------- reset ----------------
    #12;
    check_all("reset", 1'b0, 2'b00, 4'd0, 1'b0);
    @(negedge clock_i);
    reset_i = 1'b1;

    foreach (vq[i]) begin
      set_in(vq[i].run, vq[i].step, vq[i].stop, vq[i].clr, vq[i].halt);
      tick();
      check_all($sformatf("vec%0d", i), vq[i].en, vq[i].st, vq[i].cnt, 1'b0);
    end

    // held step: one enable pulse every other cycle
    pattern = '0;
    set_in(0,1,0,0,0);
    for (int i = 0; i < 6; i++) begin
      tick();
      pattern = {pattern[4:0], enable_pipe_o};
    end
    set_in(0,0,0,0,0);
    tick();
    check("step_held_pattern", 32'(pattern), 32'(6'b101010));
    check_all("step_held_end", 1'b0, 2'b00, 4'd3, 1'b0);

    // halt marker on the limit edge wins over the watchdog
    set_in(0,0,0,1,0); tick();
    set_in(1,0,0,0,0); tick();
    set_in(0,0,0,0,0);
    for (int i = 0; i < 7; i++) tick();
    check_all("wdog_pre", 1'b1, 2'b01, 4'd7, 1'b0);
    set_in(0,0,0,0,1); tick();
    check_all("wdog_halt_wins", 1'b0, 2'b11, 4'd8, 1'b0);

    // unbounded run: watchdog trip, or counter saturation without it
    set_in(0,0,0,1,0); tick();
    set_in(1,0,0,0,0); tick();
    set_in(0,0,0,0,0);
    for (int i = 0; i < 9; i++) tick();
    if (wd) check_all("wdog_trip", 1'b0, 2'b11, 4'd8, 1'b1);
    else    check_all("wdog_off_run", 1'b1, 2'b01, 4'd9, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    if (wd) check_all("wdog_hold", 1'b0, 2'b11, 4'd8, 1'b1);
    else    check_all("run_saturate", 1'b1, 2'b01, 4'd15, 1'b0);
    set_in(0,0,1,0,0); tick();
    set_in(0,0,0,1,0); tick();
    check_all("clear_after_wdog", 1'b0, 2'b00, 4'd0, 1'b0);

    // step saturation (steps are never cut by the watchdog)
    set_in(0,1,0,0,0);
    for (int i = 0; i < 40; i++) tick();
    set_in(0,0,0,0,0); tick();
    check_all("step_saturate", 1'b0, 2'b00, 4'd15, 1'b0);

    // asynchronous reset mid-run
    set_in(0,0,0,1,0); tick();
    set_in(1,0,0,0,0); tick();
    set_in(0,0,0,0,0); tick(); tick();
    check_all("pre_async_reset", 1'b1, 2'b01, 4'd2, 1'b0);
    #2;
    reset_i = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 2'b00, 4'd0, 1'b0);
    @(negedge clock_i);
    reset_i = 1'b1;
    set_in(1,0,0,0,0); tick();
    check_all("run_after_reset", 1'b1, 2'b01, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_exec_controller.md
Name: pipe_exec_controller

Overview:
Execution sequencer for the 5-stage MIPS pipeline. Drives the common enable_pipe strobe into every pipeline register (IF/ID through MEM/WB) and supports continuous run, single-step and pause. Stops the pipeline when the halt marker reaches the MEM/WB output, and counts executed pipeline cycles for the debug unit. Updates on rising edge; pipeline registers sample on falling edge, so enable_pipe_o is stable half a cycle before use.

Parameters:
NB_CNT, 32, width of executed-cycle counter
WDOG_LIMIT, 1024, max RUN cycles before forced halt (used only with PIPE_WATCHDOG_EN)

Ports:
clock_i  input  1  system clock, rising edge
reset_i  input  1  asynchronous reset, active-low
run_i  input  1  request continuous execution (level, sampled each edge)
step_i  input  1  request exactly one pipeline cycle (single-cycle pulse)
stop_i  input  1  pause continuous execution
clear_i  input  1  leave HALTED, zero counter and flags
halt_wb_i  input  1  halt_signal from MEM/WB register output
enable_pipe_o  output  1  enable to all pipeline registers
busy_o  output  1  state is RUN or STEP
halted_o  output  1  state is HALTED
state_o  output  2  current state encoding
cycle_count_o  output  NB_CNT  pipeline cycles executed since last clear
timeout_o  output  1  watchdog forced the halt

Behaviour:
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11. Registered state; all outputs decoded from registers (Moore).
- Reset (reset_i=0, asynchronous): state IDLE, enable_pipe_o=0, busy_o=0, halted_o=0, state_o=00, cycle_count_o=0, timeout_o=0. Reset asserted mid-RUN drops enable_pipe_o immediately, without waiting for a clock.
- enable_pipe_o = 1 iff state is RUN or STEP; busy_o identical.
- IDLE: run_i=1 -> RUN; else step_i=1 -> STEP; else clear_i=1 -> counter to 0, stay IDLE. run_i has priority over step_i.
- RUN: priority halt_wb_i > stop_i. halt_wb_i=1 -> HALTED; stop_i=1 -> IDLE; else stay. run_i and step_i ignored.
- STEP: lasts exactly one cycle. halt_wb_i=1 -> HALTED, else -> IDLE. Held step_i produces one step per IDLE->STEP entry, i.e. at most one step every 2 cycles.
- HALTED: enable_pipe_o=0. run_i, step_i and stop_i ignored. clear_i=1 -> IDLE, counter=0, timeout_o=0.
- halt_wb_i is sampled only in RUN and STEP. It is ignored in IDLE and HALTED.
- Latency: run_i/step_i seen at edge N -> enable_pipe_o high after edge N. halt_wb_i seen at edge M -> enable_pipe_o low after edge M. No further negedge capture occurs after that falling edge.
- Counter: increments at every rising edge where enable_pipe_o=1, including the edge that exits to HALTED. Saturates at all-ones and does not wrap. clear_i has priority over increment but is only honoured in IDLE or HALTED.
- Simultaneous run_i and stop_i in IDLE -> RUN (stop_i only acts in RUN).

Optional Feature:
PIPE_WATCHDOG_EN
- Defined: in RUN, at the edge where cycle_count_o == WDOG_LIMIT-1 (counter reaches WDOG_LIMIT), go to HALTED and set timeout_o=1. If halt_wb_i is high on that same edge, it wins and timeout_o stays 0. STEP is not subject to the watchdog. timeout_o clears on reset or clear_i.
- Undefined: timeout_o tied to 0, no comparator logic, RUN is unbounded.

Test Plan:
1. Release reset, pulse run_i 1 cycle, assert halt_wb_i on the 6th cycle of RUN -> enable_pipe_o high exactly 6 cycles, halted_o=1, state_o=11, cycle_count_o=6.
2. From IDLE hold step_i high for 6 cycles -> 3 separate 1-cycle enable pulses, cycle_count_o=3, state returns to 00.
3. RUN 4 cycles, then assert stop_i and halt_wb_i on the same edge -> HALTED (not IDLE), cycle_count_o=5.
4. In HALTED pulse run_i and step_i -> no enable; pulse clear_i -> state 00, cycle_count_o=0; then run_i -> enable resumes.
5. Drop reset_i between clock edges mid-RUN -> enable_pipe_o=0 and cycle_count_o=0 before the next rising edge.
6. With PIPE_WATCHDOG_EN and WDOG_LIMIT=8, run with halt_wb_i=0 -> HALTED after 8 enabled cycles, timeout_o=1, cycle_count_o=8. Without the macro, same stimulus keeps RUN and timeout_o=0.
